// File: rtl/savestate_pkg.sv
// rtl/savestate_pkg.sv - shared types and message codes for the savestate sequencer
package savestate_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PAUSE_WAIT,
        ST_XFER,
        ST_UNPAUSE
    } ss_state_t;

    // Kind of transfer currently owned by the sequencer
    typedef enum logic [1:0] {
        OP_SAVE,
        OP_LOAD,
        OP_RCAP,
        OP_RLOAD
    } ss_op_t;

    // Rewind ring entry index (user slots 0-3 also fit)
    typedef logic [2:0] img_idx_t;

    localparam logic [7:0] INFO_SAVE_BASE  = 8'd6;
    localparam logic [7:0] INFO_LOAD_BASE  = 8'd7;
    localparam logic [7:0] INFO_REWIND     = 8'd14;
    localparam logic [7:0] INFO_EMPTY_SLOT = 8'd16;
    localparam logic [7:0] INFO_TIMEOUT    = 8'd17;
    localparam logic [7:0] INFO_RING_EMPTY = 8'd18;

    // User slots occupy images 0-3
    function automatic logic [3:0] user_image(input logic [1:0] s);
        return {2'b00, s};
    endfunction

    // Rewind entries occupy images 4-11
    function automatic logic [3:0] rewind_image(input img_idx_t entry);
        return 4'd4 + {1'b0, entry};
    endfunction

endpackage

// File: rtl/ss_rewind_ring.sv
// rtl/ss_rewind_ring.sv - write pointer and fill count of the 8-entry rewind ring
module ss_rewind_ring
    import savestate_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     clear,
    input  logic     commit_capture,
    input  logic     commit_load,
    output img_idx_t wr_ptr,
    output img_idx_t rd_ptr,
    output logic [3:0] count
);

    img_idx_t   wr_q;
    logic [3:0] count_q;

    // Newest entry sits just behind the write pointer; 3-bit arithmetic wraps 0->7
    assign rd_ptr = wr_q - 3'd1;
    assign wr_ptr = wr_q;
    assign count  = count_q;

    // Pointer/count update; clear wins over a simultaneous commit
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_q    <= '0;
            count_q <= '0;
        end else if (commit_capture) begin
            wr_q <= wr_q + 3'd1;
            if (count_q != 4'd8) begin
                count_q <= count_q + 4'd1;
            end
        end else if (commit_load) begin
            wr_q <= wr_q - 3'd1;
            if (count_q != 4'd0) begin
                count_q <= count_q - 4'd1;
            end
        end
    end

endmodule

// File: rtl/savestate_sequencer.sv
// rtl/savestate_sequencer.sv - pause/transfer/unpause sequencing of save images and rewind captures
module savestate_sequencer
    import savestate_pkg::*;
#(
    parameter int ADDR_W       = 26,
    parameter int SLOT_SHIFT   = 20,
    parameter int TIMEOUT_BITS = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ss_save,
    input  logic              ss_load,
    input  logic [1:0]        slot,
    input  logic              rewind_enable,
    input  logic              rewind_capture,
    input  logic              rewind_load,
    output logic              pause_req,
    input  logic              pause_ack,
    output logic              xfer_start,
    output logic              xfer_dir,
    output logic [ADDR_W-1:0] xfer_addr,
    input  logic              xfer_done,
    output logic              busy,
    output logic [3:0]        slot_valid,
    output logic              ss_info_req,
    output logic [7:0]        ss_info
);

    // Watchdog fires on the edge that closes the (2^TIMEOUT_BITS-1)-th cycle in a state
    localparam logic [TIMEOUT_BITS-1:0] WD_LAST = {{(TIMEOUT_BITS-1){1'b1}}, 1'b0};

    ss_state_t               state_q, state_d;
    ss_op_t                  op_q, op_d;
    logic [1:0]              op_slot_q, op_slot_d;
    logic                    pend_valid_q, pend_valid_d;
    logic                    pend_load_q, pend_load_d;
    logic [1:0]              pend_slot_q, pend_slot_d;
    logic [3:0]              slot_valid_q, slot_valid_d;
    logic                    xfer_start_q, xfer_start_d;
    logic                    info_req_q, info_req_d;
    logic [7:0]              info_q, info_d;
    logic                    dir_q, dir_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [TIMEOUT_BITS-1:0] wd_q, wd_d;

    logic       commit_capture;
    logic       commit_load;
    logic       u_valid;
    logic       u_load;
    logic [1:0] u_slot;
    logic       timeout;
    img_idx_t   ring_wr;
    img_idx_t   ring_rd;
    logic [3:0] ring_count;

    function automatic logic [ADDR_W-1:0] image_addr(input logic [3:0] idx);
        return ADDR_W'(idx) << SLOT_SHIFT;
    endfunction

    ss_rewind_ring u_ring (
        .clk            (clk),
        .reset          (reset),
        .clear          (!rewind_enable),
        .commit_capture (commit_capture),
        .commit_load    (commit_load),
        .wr_ptr         (ring_wr),
        .rd_ptr         (ring_rd),
        .count          (ring_count)
    );

    assign pause_req   = (state_q == ST_PAUSE_WAIT) || (state_q == ST_XFER);
    assign busy        = (state_q != ST_IDLE);
    assign xfer_start  = xfer_start_q;
    assign xfer_dir    = dir_q;
    assign xfer_addr   = addr_q;
    assign slot_valid  = slot_valid_q;
    assign ss_info_req = info_req_q;
    assign ss_info     = info_q;

    // Next-state, request arbitration, completion reporting and watchdog
    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        op_slot_d      = op_slot_q;
        pend_valid_d   = pend_valid_q;
        pend_load_d    = pend_load_q;
        pend_slot_d    = pend_slot_q;
        slot_valid_d   = slot_valid_q;
        xfer_start_d   = 1'b0;
        info_req_d     = 1'b0;
        info_d         = info_q;
        dir_d          = dir_q;
        addr_d         = addr_q;
        commit_capture = 1'b0;
        commit_load    = 1'b0;
        u_valid        = 1'b0;
        u_load         = 1'b0;
        u_slot         = 2'b00;
        wd_d           = '0;
        timeout        = (wd_q == WD_LAST);

        // While busy, the latest user pulse overwrites the single pending request
        if (state_q != ST_IDLE && (ss_save || ss_load)) begin
            pend_valid_d = 1'b1;
            pend_load_d  = ss_load;
            pend_slot_d  = slot;
        end

        case (state_q)
            ST_IDLE: begin
                if (pend_valid_q) begin
                    u_valid      = 1'b1;
                    u_load       = pend_load_q;
                    u_slot       = pend_slot_q;
                    pend_valid_d = ss_save || ss_load;
                    pend_load_d  = ss_load;
                    pend_slot_d  = slot;
                end else begin
                    u_valid = ss_save || ss_load;
                    u_load  = ss_load;
                    u_slot  = slot;
                end

                if (u_valid) begin
                    if (u_load && !slot_valid_q[u_slot]) begin
                        info_req_d = 1'b1;
                        info_d     = INFO_EMPTY_SLOT;
                    end else begin
                        op_d      = u_load ? OP_LOAD : OP_SAVE;
                        op_slot_d = u_slot;
                        dir_d     = !u_load;
                        addr_d    = image_addr(user_image(u_slot));
                        state_d   = ST_PAUSE_WAIT;
                    end
                end else if (rewind_enable && rewind_load) begin
                    if (ring_count == 4'd0) begin
                        info_req_d = 1'b1;
                        info_d     = INFO_RING_EMPTY;
                    end else begin
                        op_d    = OP_RLOAD;
                        dir_d   = 1'b0;
                        addr_d  = image_addr(rewind_image(ring_rd));
                        state_d = ST_PAUSE_WAIT;
                    end
                end else if (rewind_enable && rewind_capture) begin
                    op_d    = OP_RCAP;
                    dir_d   = 1'b1;
                    addr_d  = image_addr(rewind_image(ring_wr));
                    state_d = ST_PAUSE_WAIT;
                end
            end

            ST_PAUSE_WAIT: begin
                if (pause_ack) begin
                    xfer_start_d = 1'b1;
                    state_d      = ST_XFER;
                end else if (timeout) begin
                    info_req_d = 1'b1;
                    info_d     = INFO_TIMEOUT;
                    state_d    = ST_IDLE;
                end
            end

            ST_XFER: begin
                if (xfer_done) begin
                    state_d = ST_UNPAUSE;
                    case (op_q)
                        OP_SAVE: begin
                            slot_valid_d[op_slot_q] = 1'b1;
                            info_req_d = 1'b1;
                            info_d     = INFO_SAVE_BASE + {5'b0, op_slot_q, 1'b0};
                        end
                        OP_LOAD: begin
                            info_req_d = 1'b1;
                            info_d     = INFO_LOAD_BASE + {5'b0, op_slot_q, 1'b0};
                        end
                        OP_RLOAD: begin
                            commit_load = 1'b1;
                            info_req_d  = 1'b1;
                            info_d      = INFO_REWIND;
                        end
                        OP_RCAP: begin
                            commit_capture = 1'b1;
                        end
                    endcase
                end else if (timeout) begin
                    info_req_d = 1'b1;
                    info_d     = INFO_TIMEOUT;
                    state_d    = ST_IDLE;
                end
            end

            ST_UNPAUSE: begin
                if (!pause_ack) begin
                    state_d = ST_IDLE;
                end else if (timeout) begin
                    info_req_d = 1'b1;
                    info_d     = INFO_TIMEOUT;
                    state_d    = ST_IDLE;
                end
            end
        endcase

        if (state_d == state_q && state_q != ST_IDLE) begin
            wd_d = wd_q + TIMEOUT_BITS'(1);
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            op_q         <= OP_SAVE;
            op_slot_q    <= '0;
            pend_valid_q <= 1'b0;
            pend_load_q  <= 1'b0;
            pend_slot_q  <= '0;
            slot_valid_q <= '0;
            xfer_start_q <= 1'b0;
            info_req_q   <= 1'b0;
            info_q       <= '0;
            dir_q        <= 1'b0;
            addr_q       <= '0;
            wd_q         <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            op_slot_q    <= op_slot_d;
            pend_valid_q <= pend_valid_d;
            pend_load_q  <= pend_load_d;
            pend_slot_q  <= pend_slot_d;
            slot_valid_q <= slot_valid_d;
            xfer_start_q <= xfer_start_d;
            info_req_q   <= info_req_d;
            info_q       <= info_d;
            dir_q        <= dir_d;
            addr_q       <= addr_d;
            wd_q         <= wd_d;
        end
    end

endmodule

// File: tb/tb_savestate_sequencer.sv
// tb/tb_savestate_sequencer.sv - self-checking bench for savestate_sequencer
module tb_savestate_sequencer;

    localparam int AW    = 26;
    localparam int SHIFT = 20;
    localparam int TOB   = 6;
    localparam int TMAX  = (1 << TOB) - 1;

    localparam int K_SAVE  = 0;
    localparam int K_LOAD  = 1;
    localparam int K_RCAP  = 2;
    localparam int K_RLOAD = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ss_save = 1'b0;
    logic          ss_load = 1'b0;
    logic [1:0]    slot = 2'b00;
    logic          rewind_enable = 1'b0;
    logic          rewind_capture = 1'b0;
    logic          rewind_load = 1'b0;
    logic          pause_req;
    logic          pause_ack = 1'b0;
    logic          xfer_start;
    logic          xfer_dir;
    logic [AW-1:0] xfer_addr;
    logic          xfer_done = 1'b0;
    logic          busy;
    logic [3:0]    slot_valid;
    logic          ss_info_req;
    logic [7:0]    ss_info;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    savestate_sequencer #(
        .ADDR_W       (AW),
        .SLOT_SHIFT   (SHIFT),
        .TIMEOUT_BITS (TOB)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ss_save        (ss_save),
        .ss_load        (ss_load),
        .slot           (slot),
        .rewind_enable  (rewind_enable),
        .rewind_capture (rewind_capture),
        .rewind_load    (rewind_load),
        .pause_req      (pause_req),
        .pause_ack      (pause_ack),
        .xfer_start     (xfer_start),
        .xfer_dir       (xfer_dir),
        .xfer_addr      (xfer_addr),
        .xfer_done      (xfer_done),
        .busy           (busy),
        .slot_valid     (slot_valid),
        .ss_info_req    (ss_info_req),
        .ss_info        (ss_info)
    );

    always #5 clk = ~clk;

    function automatic logic [AW-1:0] addr_of(input int idx);
        logic [63:0] w;
        w = 64'(idx) << SHIFT;
        return w[AW-1:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 waiting for pause, 2 moving data, 3 waiting for release
    int         m_phase = 0;
    int         m_age = 0;
    int         m_kind = 0;
    int         m_slot = 0;
    bit         m_pend = 0;
    bit         m_pend_load = 0;
    int         m_pend_slot = 0;
    logic [3:0] m_valid = '0;
    int         m_wr = 0;
    int         m_cnt = 0;
    bit         m_start = 0;
    bit         m_info_req = 0;
    int         m_info = 0;
    bit         m_dir = 0;
    logic [AW-1:0] m_addr = '0;
    int         m_old;
    bit         m_go;
    bit         m_ld;
    int         m_sl;
    bit         m_to;

    always @(posedge clk) begin
        m_start    = 0;
        m_info_req = 0;
        if (reset) begin
            m_phase = 0; m_age = 0; m_pend = 0; m_valid = '0; m_wr = 0; m_cnt = 0;
            m_info = 0; m_dir = 0; m_addr = '0;
        end else begin
            m_old = m_phase;
            m_to  = (m_phase != 0) && (m_age + 1 == TMAX);
            if (m_phase != 0 && (ss_save || ss_load)) begin
                m_pend = 1; m_pend_load = ss_load; m_pend_slot = slot;
            end
            case (m_phase)
                0: begin
                    if (m_pend) begin
                        m_go = 1; m_ld = m_pend_load; m_sl = m_pend_slot;
                        m_pend = ss_save || ss_load;
                        m_pend_load = ss_load; m_pend_slot = slot;
                    end else begin
                        m_go = ss_save || ss_load; m_ld = ss_load; m_sl = slot;
                    end
                    if (m_go) begin
                        if (m_ld && !m_valid[m_sl]) begin
                            m_info_req = 1; m_info = 16;
                        end else begin
                            m_kind = m_ld ? K_LOAD : K_SAVE; m_slot = m_sl;
                            m_dir = !m_ld; m_addr = addr_of(m_sl); m_phase = 1;
                        end
                    end else if (rewind_enable && rewind_load) begin
                        if (m_cnt == 0) begin
                            m_info_req = 1; m_info = 18;
                        end else begin
                            m_kind = K_RLOAD; m_dir = 0;
                            m_addr = addr_of(4 + (m_wr + 7) % 8); m_phase = 1;
                        end
                    end else if (rewind_enable && rewind_capture) begin
                        m_kind = K_RCAP; m_dir = 1; m_addr = addr_of(4 + m_wr); m_phase = 1;
                    end
                end
                1: begin
                    if (pause_ack) begin
                        m_start = 1; m_phase = 2;
                    end else if (m_to) begin
                        m_phase = 0; m_info_req = 1; m_info = 17;
                    end
                end
                2: begin
                    if (xfer_done) begin
                        m_phase = 3;
                        if (m_kind == K_SAVE) begin
                            m_valid[m_slot] = 1'b1; m_info_req = 1; m_info = 6 + 2 * m_slot;
                        end else if (m_kind == K_LOAD) begin
                            m_info_req = 1; m_info = 7 + 2 * m_slot;
                        end else if (m_kind == K_RLOAD) begin
                            m_wr = (m_wr + 7) % 8; m_cnt = m_cnt - 1; m_info_req = 1; m_info = 14;
                        end else begin
                            m_wr = (m_wr + 1) % 8; if (m_cnt < 8) m_cnt = m_cnt + 1;
                        end
                    end else if (m_to) begin
                        m_phase = 0; m_info_req = 1; m_info = 17;
                    end
                end
                default: begin
                    if (!pause_ack) begin
                        m_phase = 0;
                    end else if (m_to) begin
                        m_phase = 0; m_info_req = 1; m_info = 17;
                    end
                end
            endcase
            m_age = (m_phase != m_old || m_phase == 0) ? 0 : m_age + 1;
            if (!rewind_enable) begin
                m_wr = 0; m_cnt = 0;
            end
        end
    end

    // Compare DUT against the model every cycle, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("pause_req", pause_req, (m_phase == 1 || m_phase == 2));
            check("busy", busy, (m_phase != 0));
            check("xfer_start", xfer_start, m_start);
            check("ss_info_req", ss_info_req, m_info_req);
            check("ss_info", ss_info, m_info[7:0]);
            check("slot_valid", slot_valid, m_valid);
            if (m_phase == 2) begin
                check("xfer_dir", xfer_dir, m_dir);
                check("xfer_addr", xfer_addr, m_addr);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    function automatic logic cur_sig(input int sel);
        case (sel)
            0:       return pause_req;
            1:       return xfer_start;
            default: return busy;
        endcase
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_sig(input string name, input int sel, input logic lvl, input int budget);
        int n;
        n = 0;
        while (cur_sig(sel) !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, cur_sig(sel), lvl);
    endtask

    task automatic begin_xfer(input int ack_delay, input logic exp_dir, input logic [AW-1:0] exp_addr);
        wait_sig("wait_pause_req_hi", 0, 1'b1, 8);
        cyc(ack_delay);
        pause_ack = 1'b1;
        wait_sig("wait_xfer_start", 1, 1'b1, 8);
        check("lit_xfer_dir", xfer_dir, exp_dir);
        check("lit_xfer_addr", xfer_addr, exp_addr);
    endtask

    task automatic end_xfer(input int done_delay);
        cyc(done_delay);
        xfer_done = 1'b1;
        cyc(1);
        xfer_done = 1'b0;
        wait_sig("wait_pause_req_lo", 0, 1'b0, 4);
        pause_ack = 1'b0;
        wait_sig("wait_busy_lo", 2, 1'b0, 4);
    endtask

    task automatic pulse_user(input bit load, input logic [1:0] s);
        slot = s;
        if (load) ss_load = 1'b1; else ss_save = 1'b1;
        cyc(1);
        ss_load = 1'b0;
        ss_save = 1'b0;
    endtask

    initial begin
        int n;
        // reset state
        cyc(3);
        check("rst_pause_req", pause_req, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_slot_valid", slot_valid, 4'b0000);
        check("rst_ss_info", ss_info, 8'd0);
        check("rst_xfer_addr", xfer_addr, '0);
        chk_en = 1'b1;
        reset  = 1'b0;
        cyc(2);

        // load of an empty slot: no pause, info 16 next cycle
        pulse_user(1'b1, 2'd1);
        check("empty_load_info_req", ss_info_req, 1'b1);
        check("empty_load_info", ss_info, 8'd16);
        check("empty_load_no_pause", pause_req, 1'b0);
        cyc(2);

        // save slot 2
        pulse_user(1'b0, 2'd2);
        begin_xfer(3, 1'b1, 26'h0200000);
        end_xfer(10);
        check("save2_slot_valid", slot_valid, 4'b0100);
        check("save2_info", ss_info, 8'd10);

        // load slot 2
        pulse_user(1'b1, 2'd2);
        begin_xfer(1, 1'b0, 26'h0200000);
        end_xfer(2);
        check("load2_info", ss_info, 8'd11);

        // nine rewind captures, then two rewind loads
        rewind_enable = 1'b1;
        cyc(1);
        for (int k = 0; k < 9; k++) begin
            rewind_capture = 1'b1;
            cyc(1);
            rewind_capture = 1'b0;
            begin_xfer(1, 1'b1, addr_of(4 + k % 8));
            end_xfer(2);
        end
        check("ring_count_sat", dut.u_ring.count, 4'd8);
        rewind_load = 1'b1;
        cyc(1);
        rewind_load = 1'b0;
        begin_xfer(1, 1'b0, 26'h0400000);
        end_xfer(2);
        check("rload1_info", ss_info, 8'd14);
        rewind_load = 1'b1;
        cyc(1);
        rewind_load = 1'b0;
        begin_xfer(1, 1'b0, 26'h0B00000);
        end_xfer(2);
        check("rload2_info", ss_info, 8'd14);
        check("ring_count_after", dut.u_ring.count, 4'd6);

        // disabled rewind ignores pulses and empties the ring
        rewind_enable = 1'b0;
        rewind_load   = 1'b1;
        cyc(1);
        check("rw_disabled_no_pause", pause_req, 1'b0);
        check("rw_disabled_no_info", ss_info_req, 1'b0);
        rewind_enable = 1'b1;
        cyc(1);
        check("ring_empty_info_req", ss_info_req, 1'b1);
        check("ring_empty_info", ss_info, 8'd18);
        rewind_load = 1'b0;
        cyc(2);

        // pending request: latest user pulse while busy wins
        pulse_user(1'b0, 2'd1);
        begin_xfer(1, 1'b1, 26'h0100000);
        pulse_user(1'b0, 2'd0);
        pulse_user(1'b0, 2'd3);
        end_xfer(2);
        begin_xfer(1, 1'b1, 26'h0300000);
        end_xfer(2);
        cyc(5);
        check("pending_idle", busy, 1'b0);
        check("pending_slot_valid", slot_valid, 4'b1110);
        check("pending_info", ss_info, 8'd12);

        // watchdog: pause never acknowledged
        pulse_user(1'b0, 2'd0);
        n = 0;
        while (pause_req === 1'b1 && n < 200) begin
            n++;
            cyc(1);
        end
        check("timeout_cycles", n, TMAX);
        check("timeout_info_req", ss_info_req, 1'b1);
        check("timeout_info", ss_info, 8'd17);
        check("timeout_busy", busy, 1'b0);
        check("timeout_slot_valid", slot_valid, 4'b1110);
        cyc(3);

        // reset in the middle of a transfer
        pulse_user(1'b0, 2'd0);
        begin_xfer(1, 1'b1, 26'h0000000);
        cyc(2);
        reset = 1'b1;
        cyc(1);
        check("midrst_pause_req", pause_req, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_xfer_start", xfer_start, 1'b0);
        check("midrst_xfer_dir", xfer_dir, 1'b0);
        check("midrst_xfer_addr", xfer_addr, '0);
        check("midrst_slot_valid", slot_valid, 4'b0000);
        check("midrst_info_req", ss_info_req, 1'b0);
        check("midrst_info", ss_info, 8'd0);
        pause_ack = 1'b0;
        reset     = 1'b0;
        cyc(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
